// File: rtl/jstk_spi_responder.sv
// PmodJSTK-compatible SPI responder: synchronizes SCLK/CS/MOSI into clk, shifts out a
// 5-byte X/Y/button report and captures the master's LED command byte.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [2:0] i_btn,
  output logic [1:0] o_led,
  output logic       o_frame_done,
  output logic       o_frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state;
  logic [39:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  cmd;
  logic [5:0]  bit_cnt;
  logic [7:0]  rx_next;

  // CS chain resets to 1 so release of reset with CS idle never looks like a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    cs_s      = cs_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    cs_rise   = cs_s & ~cs_d;
    cs_fall   = ~cs_s & cs_d;
    rx_next   = {rx_sr[6:0], mosi_s};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      tx_sr        <= '0;
      rx_sr        <= '0;
      cmd          <= '0;
      bit_cnt      <= '0;
      o_miso       <= 1'b0;
      o_miso_oe    <= 1'b0;
      o_led        <= 2'b00;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            tx_sr     <= {i_x[7:0], 6'b0, i_x[9:8], i_y[7:0], 6'b0, i_y[9:8], 5'b0, i_btn};
            bit_cnt   <= '0;
            cmd       <= '0;
            o_miso_oe <= 1'b1;
            o_miso    <= i_x[7];
          end
        end
        SHIFT: begin
          // A CS rise takes priority; any SCLK edge in the same cycle is dropped.
          if (cs_rise) begin
            state     <= IDLE;
            o_miso_oe <= 1'b0;
            o_miso    <= 1'b0;
            if (bit_cnt >= FRAME_BITS) begin
              o_frame_done <= 1'b1;
              if (cmd[7]) o_led <= cmd[1:0];
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_sr <= rx_next;
              if (bit_cnt != FRAME_BITS) bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) cmd <= rx_next;
            end
            if (sclk_fall) begin
              tx_sr  <= {tx_sr[38:0], 1'b0};
              o_miso <= tx_sr[38];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: a mode-0 SPI master model drives frames while a
// byte scoreboard and pulse/LED checks verify the responder.
module tb_jstk_spi_responder;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_sclk = 1'b0, i_cs_n = 1'b1, i_mosi = 1'b0;
  logic       o_miso, o_miso_oe;
  logic [9:0] i_x = '0, i_y = '0;
  logic [2:0] i_btn = '0;
  logic [1:0] o_led;
  logic       o_frame_done, o_frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [1:0] led_model = 2'b00;

  jstk_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn),
    .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe),
    .i_x(i_x), .i_y(i_y), .i_btn(i_btn),
    .o_led(o_led), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_frame_done) done_seen <= done_seen + 1;
    if (o_frame_err)  err_seen  <= err_seen + 1;
  end

  function automatic logic [7:0] report_byte(input int idx);
    case (idx)
      0: return i_x[7:0];
      1: return {6'b0, i_x[9:8]};
      2: return i_y[7:0];
      3: return {6'b0, i_y[9:8]};
      4: return {5'b0, i_btn};
      default: return 8'h00;
    endcase
  endfunction

  // Drives one frame of nbits SCLK cycles. snap_bit>0 zeroes i_x after that many bits;
  // rst_bit>0 asserts rstn after that many bits instead of ending the frame normally.
  task automatic run_frame(input logic [7:0] cmd, input int nbits, input int snap_bit,
                           input int rst_bit);
    int         run_bits;
    int         d0, e0;
    logic [7:0] rx, exp;
    logic       exp_done;
    run_bits = (rst_bit > 0) ? rst_bit : nbits;
    for (int b = 0; b < run_bits / 8; b++) exp_q.push_back(report_byte(b));
    d0 = done_seen;
    e0 = err_seen;
    rx = '0;

    @(negedge clk) i_cs_n = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (o_miso_oe !== 1'b0) begin
      n_bad++; $display("FAIL oe_early: got %b want 0", o_miso_oe);
    end
    @(negedge clk);
    n_cmp++;
    if (o_miso_oe !== 1'b1) begin
      n_bad++; $display("FAIL oe_latency: got %b want 1", o_miso_oe);
    end
    repeat (HALF - LAT) @(negedge clk);

    for (int i = 0; i < run_bits; i++) begin
      i_mosi = (i < 8) ? cmd[7 - i] : 1'b0;
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], o_miso};
      i_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      i_sclk = 1'b0;
      if (i % 8 == 7) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL miso_byte%0d: got %h want <none queued>", i / 8, rx);
        end else begin
          exp = exp_q.pop_front();
          if (rx !== exp) begin
            n_bad++; $display("FAIL miso_byte%0d: got %h want %h", i / 8, rx, exp);
          end
        end
      end
      if (snap_bit > 0 && i + 1 == snap_bit) i_x = 10'h000;
    end

    if (rst_bit > 0) begin
      rstn = 1'b0;
      #1;
      n_cmp++;
      if (o_miso_oe !== 1'b0 || o_led !== 2'b00) begin
        n_bad++; $display("FAIL reset_mid: oe=%b led=%b want oe=0 led=00", o_miso_oe, o_led);
      end
      led_model = 2'b00;
      i_cs_n = 1'b1;
      i_mosi = 1'b0;
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (done_seen != d0 || err_seen != e0) begin
        n_bad++; $display("FAIL reset_no_pulse: done=%0d err=%0d want 0 0",
                          done_seen - d0, err_seen - e0);
      end
      return;
    end

    repeat (HALF) @(negedge clk);
    i_cs_n = 1'b1;
    exp_done = (nbits >= 40);
    if (exp_done && cmd[7]) led_model = cmd[1:0];
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (o_frame_done !== 1'b0 || o_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL pulse_early: done=%b err=%b want 0 0", o_frame_done, o_frame_err);
    end
    @(negedge clk);
    n_cmp++;
    if (o_frame_done !== exp_done || o_frame_err !== !exp_done || o_led !== led_model) begin
      n_bad++; $display("FAIL frame_end: done=%b err=%b led=%b want done=%b err=%b led=%b",
                        o_frame_done, o_frame_err, o_led, exp_done, !exp_done, led_model);
    end
    @(negedge clk);
    n_cmp++;
    if (o_frame_done !== 1'b0 || o_frame_err !== 1'b0 || o_miso_oe !== 1'b0) begin
      n_bad++; $display("FAIL pulse_width: done=%b err=%b oe=%b want 0 0 0",
                        o_frame_done, o_frame_err, o_miso_oe);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_seen - d0 != int'(exp_done) || err_seen - e0 != int'(!exp_done)) begin
      n_bad++; $display("FAIL pulse_count: done=%0d err=%0d want %0d %0d",
                        done_seen - d0, err_seen - e0, exp_done, !exp_done);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_miso !== 1'b0 || o_miso_oe !== 1'b0 || o_led !== 2'b00 ||
        o_frame_done !== 1'b0 || o_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: miso=%b oe=%b led=%b done=%b err=%b want all 0",
                        o_miso, o_miso_oe, o_led, o_frame_done, o_frame_err);
    end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_frame();
    i_x = 10'h2A5; i_y = 10'h13C; i_btn = 3'b101;
    run_frame(8'h81, 40, 0, 0);
  endtask

  task automatic test_invalid_cmd();
    run_frame(8'h03, 40, 0, 0);
  endtask

  task automatic test_snapshot();
    i_x = 10'h2A5;
    run_frame(8'h81, 40, 3, 0);
    i_x = 10'h2A5;
  endtask

  task automatic test_short_frame();
    run_frame(8'h82, 17, 0, 0);
    i_x = 10'h15A; i_y = 10'h2C3; i_btn = 3'b010;
    run_frame(8'h82, 40, 0, 0);
  endtask

  task automatic test_overlength();
    run_frame(8'h83, 48, 0, 0);
  endtask

  task automatic test_cs_only();
    run_frame(8'h00, 0, 0, 0);
  endtask

  task automatic test_reset_midframe();
    run_frame(8'h81, 40, 0, 20);
    i_x = 10'h3FF; i_y = 10'h001; i_btn = 3'b111;
    run_frame(8'h81, 40, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_invalid_cmd();
    test_snapshot();
    test_short_frame();
    test_overlength();
    test_cs_only();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI responder that emulates the PmodJSTK joystick: the far end of the SCLK/SS/MISO link driven by the SoC's joystick SPI master. It samples the master's SCLK, chip select and MOSI in its own clock domain and shifts out a 5-byte X/Y/button report. It also captures the master's LED command byte. It is used as a loopback target on a second PMOD and as the bus-functional device in the joystick-controller testbench.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on i_sclk, i_cs_n and i_mosi; legal values are 2 and 3.

Ports:
- clk  in  1  system clock; the block has only this one clock.
- rstn  in  1  reset, asynchronous and active-low.
- i_sclk  in  1  SPI clock from the master, asynchronous to clk, idle low (mode 0).
- i_cs_n  in  1  chip select from the master, active-low.
- i_mosi  in  1  master-out data, MSB first.
- o_miso  out  1  responder-out data, MSB first.
- o_miso_oe  out  1  MISO drive enable; the top level tristates the pin when this is 0.
- i_x  in  10  joystick X position.
- i_y  in  10  joystick Y position.
- i_btn  in  3  button states: {btn2, btn1, stick}.
- o_led  out  2  LED bits from the last valid command byte.
- o_frame_done  out  1  one-cycle pulse when a complete frame ends.
- o_frame_err  out  1  one-cycle pulse when a frame is aborted early.

## Operation
Input conditioning:
- i_sclk, i_cs_n and i_mosi each pass through SYNC_STAGES flops.
- Reset value of the i_sclk and i_mosi chains is 0; reset value of the i_cs_n chain is 1.
- Edges are detected by comparing the last synchronizer stage with one extra registered copy.
- Requirement on the master: SCLK high and low phases each last at least SYNC_STAGES+2 clk cycles.

Frame format (mode 0, 40 bits, MSB first):
- MISO bytes, in order: X[7:0], {6'b0, X[9:8]}, Y[7:0], {6'b0, Y[9:8]}, {5'b0, btn}.
- MOSI byte 0 is the command; bytes 1–4 are don't-care.
- The command is valid when bit7 = 1; it then carries LED[1:0] in bits [1:0].

State machine (IDLE, SHIFT):
- IDLE, on a synchronized CS falling edge → SHIFT:
  - Snapshot {i_x, i_y, i_btn} into a 40-bit transmit register.
  - Clear the bit counter (6 bits).
  - Set o_miso_oe = 1.
  - Drive o_miso from transmit bit 39.
- SHIFT, on each synchronized SCLK rising edge:
  - Shift the MOSI sample into the 8-bit receive register.
  - Increment the bit counter; it saturates at 40.
  - When the counter reaches 8, latch the command byte.
- SHIFT, on each synchronized SCLK falling edge:
  - Shift the transmit register left, filling with 0.
  - o_miso then presents the next bit.
  - After bit 40, o_miso stays 0.
- SHIFT, on a synchronized CS rising edge → IDLE, with o_miso_oe = 0 and o_miso = 0:
  - If the counter is ≥ 40: pulse o_frame_done. If the latched command has bit7 = 1, load o_led from its bits [1:0] in the same cycle. If bit7 = 0, o_led holds.
  - If the counter is < 40: pulse o_frame_err and leave o_led unchanged.
- SCLK edges seen while in IDLE are ignored.
- Extra clocks beyond 40 shift out zeros and do not cause an error.

Boundary conditions:
- Snapshot isolation: changes on i_x/i_y/i_btn during a frame do not affect that frame.
- CS falls and rises with no SCLK edges: counter is 0, so o_frame_err pulses.
- CS rise and SCLK edge in the same cycle: the CS rise wins and the SCLK edge is discarded.
- rstn asserted mid-frame: return to IDLE immediately and apply all reset values. The interrupted frame raises no pulse.

## Timing
Reset values:
- o_miso = 0, o_miso_oe = 0, o_led = 2'b00.
- o_frame_done = 0, o_frame_err = 0.
- State IDLE, counter 0, transmit and receive registers 0.

Latencies:
- Every pin-to-effect latency is SYNC_STAGES+1 clk cycles from the pin transition to the registered response.
- CS fall → o_miso_oe = 1 with valid bit 39: SYNC_STAGES+1 cycles.
- SCLK fall → next MISO bit: SYNC_STAGES+1 cycles. The master samples on the following rising edge, so the SCLK low phase must exceed this latency.
- CS rise → done/err pulse and o_led update: SYNC_STAGES+1 cycles; the pulse lasts exactly 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Full frame: i_x = 10'h2A5, i_y = 10'h13C, i_btn = 3'b101, MOSI = 0x81 then 4×0x00, SCLK = clk/16 → MISO bytes A5, 02, 3C, 01, 05. o_frame_done pulses once; o_led = 2'b01.
- Invalid command: MOSI byte 0 = 0x03 → MISO report correct, o_frame_done = 1, o_led unchanged from 2'b01.
- Snapshot: change i_x from 0x2A5 to 0x000 after bit 3 → the frame still returns A5, 02.
- Short frame: CS raised after 17 bits → o_frame_err pulses, no o_frame_done, o_led unchanged. The next full frame is correct.
- Over-length: 48 SCLKs → last byte shifted out is 00; o_frame_done pulses, no error.
- Reset: rstn low after bit 20 → o_miso_oe = 0 and o_led = 00 immediately. No pulse. A subsequent frame works.
